// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared types for the register-transfer controller: per-register bus ops,
// the FSM state encoding, and the request legality rule.
package bus_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_OP_NONE  = 2'd0,
    REG_OP_READ  = 2'd1,
    REG_OP_WRITE = 2'd2
  } reg_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } xfer_state_t;

  // A register-sourced move needs a distinct, in-range source; an immediate ignores src.
  function automatic logic req_illegal(input logic [15:0] src, input logic [15:0] dst,
                                       input logic imm_en, input int unsigned num_regs);
    return (32'(dst) >= num_regs) ||
           (!imm_en && ((32'(src) >= num_regs) || (src == dst)));
  endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Request handshake and per-register control bundle between a requester
// (master) and the transfer controller (slave).
interface bus_xfer_ctrl_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 4
);
  import bus_xfer_ctrl_pkg::*;

  logic                      req_valid;
  logic                      req_ready;
  logic [IDX_W-1:0]          req_src;
  logic [IDX_W-1:0]          req_dst;
  logic                      req_imm_en;
  logic [WIDTH-1:0]          req_imm;
  reg_op_t [NUM_REGS-1:0]    reg_op;
  logic                      done;
  logic                      err;
  logic [7:0]                xfer_count;

  modport master (
    output req_valid, req_src, req_dst, req_imm_en, req_imm,
    input  req_ready, reg_op, done, err, xfer_count
  );

  modport slave (
    input  req_valid, req_src, req_dst, req_imm_en, req_imm,
    output req_ready, reg_op, done, err, xfer_count
  );

endinterface

// File: rtl/bus_xfer_ctrl.sv
// Controls single-cycle moves over a shared bus between NUM_REGS registers,
// or loads an immediate driven onto the bus, one transfer every 3 cycles.
module bus_xfer_ctrl
  import bus_xfer_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_xfer_ctrl_if.slave    bus,
  output logic [WIDTH-1:0]  bus_out
);

  xfer_state_t            state_q;
  logic [IDX_W-1:0]       src_q;
  logic [IDX_W-1:0]       dst_q;
  logic                   imm_en_q;
  logic [WIDTH-1:0]       imm_q;
  logic                   done_q;
  logic                   err_q;
  logic [7:0]             count_q;
  reg_op_t [NUM_REGS-1:0] op_dec;
  logic                   illegal;

  assign illegal = req_illegal(16'(bus.req_src), 16'(bus.req_dst), bus.req_imm_en, NUM_REGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      imm_en_q <= 1'b0;
      imm_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            src_q    <= bus.req_src;
            dst_q    <= bus.req_dst;
            imm_en_q <= bus.req_imm_en;
            imm_q    <= bus.req_imm;
            if (illegal) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= XFER;
            end
          end
        end
        XFER: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          count_q <= count_q + 8'd1;
        end
        DONE:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ops decode only from state and captured fields, so nothing from req_* reaches the register controls.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      op_dec[i] = REG_OP_NONE;
      if (state_q == XFER) begin
        if (IDX_W'(i) == dst_q)
          op_dec[i] = REG_OP_READ;
        else if (!imm_en_q && (IDX_W'(i) == src_q))
          op_dec[i] = REG_OP_WRITE;
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.reg_op     = op_dec;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.xfer_count = count_q;
  assign bus_out        = (state_q == XFER && imm_en_q) ? imm_q : 'z;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: models the register file on the shared bus and
// checks each transfer against a transfer-level reference.
module tb_bus_xfer_ctrl;
  import bus_xfer_ctrl_pkg::*;

  localparam int WIDTH    = 8;
  localparam int NUM_REGS = 4;
  localparam int IDX_W    = 4;

  logic clk = 1'b0;
  logic rst_n;
  wire [WIDTH-1:0] bus_out;

  bus_xfer_ctrl_if #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) ifc ();

  bus_xfer_ctrl #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc),
    .bus_out (bus_out)
  );

  always #5 clk = ~clk;

  // Bus-attached registers: latch on negedge when told to READ, from the writer or the bus.
  logic [7:0] regs [NUM_REGS] = '{8'h00, 8'hA5, 8'h00, 8'h00};
  always @(negedge clk) begin
    int w;
    w = -1;
    for (int i = 0; i < NUM_REGS; i++)
      if (ifc.reg_op[i] == REG_OP_WRITE) w = i;
    for (int i = 0; i < NUM_REGS; i++)
      if (ifc.reg_op[i] == REG_OP_READ) regs[i] <= (w >= 0) ? regs[w] : bus_out;
  end

  // Transfer-level reference.
  logic [7:0] model [NUM_REGS];
  logic [7:0] model_cnt;

  int vectors;
  int miscompares;

  typedef struct {
    logic [3:0] src;
    logic [3:0] dst;
    logic       imm_en;
    logic [7:0] imm;
    logic       exp_err;
    logic [7:0] exp_val;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic chk_z(input string name);
    vectors++;
    if (!(bus_out === 8'bzzzzzzzz || bus_out == 8'h00)) begin
      miscompares++;
      $display("FAIL %s: bus_out got %0h, expected z", name, bus_out);
    end
  endtask

  task automatic chk_ops_none(input string name);
    for (int i = 0; i < NUM_REGS; i++)
      chk($sformatf("%s_op%0d", name, i), 32'(ifc.reg_op[i]), 32'(REG_OP_NONE));
  endtask

  function automatic logic legal(input logic [3:0] s, input logic [3:0] d, input logic ie);
    return (d < NUM_REGS) && (ie || ((s < NUM_REGS) && (s != d)));
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ifc.req_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", ifc.req_ready, 1);
  endtask

  task automatic do_xfer(input logic [3:0] s, input logic [3:0] d, input logic ie,
                         input logic [7:0] im, output logic saw_err);
    logic ok;
    logic [7:0] ev;
    reg_op_t eop;
    ok = legal(s, d, ie);
    ev = (ok && !ie) ? model[s[1:0]] : im;
    wait_ready();
    ifc.req_src = s; ifc.req_dst = d; ifc.req_imm_en = ie; ifc.req_imm = im;
    ifc.req_valid = 1'b1;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    saw_err = ifc.err;
    chk("acc_ready", ifc.req_ready, 0);
    chk("acc_err", ifc.err, 32'(!ok));
    chk("acc_done", ifc.done, 0);
    for (int i = 0; i < NUM_REGS; i++) begin
      eop = REG_OP_NONE;
      if (ok && i == int'(d)) eop = REG_OP_READ;
      else if (ok && !ie && i == int'(s)) eop = REG_OP_WRITE;
      chk($sformatf("acc_op%0d", i), 32'(ifc.reg_op[i]), 32'(eop));
    end
    if (ok && ie) chk("acc_bus", bus_out, im);
    else chk_z("acc_bus_z");
    @(posedge clk); #1;
    if (ok) begin
      model[d[1:0]] = ev;
      model_cnt = model_cnt + 8'd1;
    end
    chk("fin_done", ifc.done, 32'(ok));
    chk("fin_err", ifc.err, 0);
    chk("fin_cnt", ifc.xfer_count, model_cnt);
    chk_z("fin_bus_z");
    chk_ops_none("fin");
    for (int i = 0; i < NUM_REGS; i++)
      chk($sformatf("reg%0d", i), regs[i], model[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic e;
    logic [3:0] s, d;
    logic ie;
    logic [7:0] im;

    vectors = 0; miscompares = 0;
    model = '{8'h00, 8'hA5, 8'h00, 8'h00};
    model_cnt = 8'd0;
    ifc.req_valid = 1'b0; ifc.req_src = '0; ifc.req_dst = '0;
    ifc.req_imm_en = 1'b0; ifc.req_imm = '0;

    tbl[0] = '{4'd1,  4'd2,  1'b0, 8'h00, 1'b0, 8'hA5};
    tbl[1] = '{4'd0,  4'd0,  1'b1, 8'h3C, 1'b0, 8'h3C};
    tbl[2] = '{4'd3,  4'd3,  1'b0, 8'h11, 1'b1, 8'h00};
    tbl[3] = '{4'd0,  4'd4,  1'b1, 8'h22, 1'b1, 8'h00};
    tbl[4] = '{4'd5,  4'd1,  1'b0, 8'h33, 1'b1, 8'h00};
    tbl[5] = '{4'd4,  4'd1,  1'b1, 8'h77, 1'b0, 8'h77};
    tbl[6] = '{4'd0,  4'd3,  1'b0, 8'h00, 1'b0, 8'h3C};
    tbl[7] = '{4'd2,  4'd0,  1'b0, 8'h00, 1'b0, 8'hA5};
    tbl[8] = '{4'd15, 4'd15, 1'b1, 8'h44, 1'b1, 8'h00};

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", ifc.req_ready, 1);
    chk("rst_done", ifc.done, 0);
    chk("rst_err", ifc.err, 0);
    chk("rst_cnt", ifc.xfer_count, 0);
    chk_z("rst_bus_z");
    chk_ops_none("rst");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", ifc.req_ready, 1);

    // Directed table
    for (int k = 0; k < 9; k++) begin
      do_xfer(tbl[k].src, tbl[k].dst, tbl[k].imm_en, tbl[k].imm, e);
      chk($sformatf("tbl%0d_err", k), e, tbl[k].exp_err);
      if (!tbl[k].exp_err)
        chk($sformatf("tbl%0d_val", k), regs[tbl[k].dst[1:0]], tbl[k].exp_val);
    end
    chk("tbl_cnt", ifc.xfer_count, 5);

    // Back-to-back with req_valid held: acceptances 3 cycles apart
    wait_ready();
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin s = 4'd1; d = 4'd2; ie = 1'b0; im = 8'h00; end
        1:       begin s = 4'd0; d = 4'd3; ie = 1'b1; im = 8'h5A; end
        default: begin s = 4'd3; d = 4'd0; ie = 1'b0; im = 8'h00; end
      endcase
      ifc.req_src = s; ifc.req_dst = d; ifc.req_imm_en = ie; ifc.req_imm = im;
      ifc.req_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_xfer_ready", ifc.req_ready, 0);
      chk("b2b_xfer_done", ifc.done, 0);
      @(posedge clk); #1;
      model[d[1:0]] = ie ? im : model[s[1:0]];
      model_cnt = model_cnt + 8'd1;
      chk("b2b_done_ready", ifc.req_ready, 0);
      chk("b2b_done", ifc.done, 1);
      chk("b2b_cnt", ifc.xfer_count, model_cnt);
      chk("b2b_reg", regs[d[1:0]], model[d[1:0]]);
      if (k == 2) ifc.req_valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b_idle_ready", ifc.req_ready, 1);
      chk("b2b_idle_done", ifc.done, 0);
    end

    // Randomized requests against the reference
    for (int k = 0; k < 60; k++) begin
      s  = 4'($urandom_range(0, 5));
      d  = 4'($urandom_range(0, 4));
      ie = 1'($urandom_range(0, 1));
      im = 8'($urandom);
      do_xfer(s, d, ie, im, e);
    end

    // Reset in the middle of an XFER cycle
    wait_ready();
    ifc.req_src = 4'd0; ifc.req_dst = 4'd2; ifc.req_imm_en = 1'b1; ifc.req_imm = ~model[2];
    ifc.req_valid = 1'b1;
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    chk("mid_xfer_ready", ifc.req_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_ops_none("mid_rst");
    chk_z("mid_rst_bus_z");
    chk("mid_rst_done", ifc.done, 0);
    chk("mid_rst_cnt", ifc.xfer_count, 0);
    model_cnt = 8'd0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_ready", ifc.req_ready, 1);
    chk("mid_rel_done", ifc.done, 0);
    chk("mid_rel_reg2", regs[2], model[2]);

    // Counter wrap after 256 completions
    for (int k = 0; k < 256; k++) begin
      d  = 4'(k % NUM_REGS);
      im = 8'(k + 1);
      do_xfer(4'd0, d, 1'b1, im, e);
    end
    chk("wrap_zero", ifc.xfer_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
